// File: rtl/tone_gen_multi.sv
// N-channel square-wave tone generator: per-channel half-period dividers, clamped shared
// volume, global mute and a linear per-tick level ramp feeding a registered PCM output.
module tone_gen_multi #(
    parameter int              NUM_CH   = 2,
    parameter int              DIV_W    = 22,
    parameter int              AUD_W    = 16,
    parameter int              VOL_W    = 3,
    parameter int              MAX_VOL  = 5,
    parameter logic [AUD_W-1:0] AMP_HI  = 16'h0E00,
    parameter logic [AUD_W-1:0] AMP_LO  = 16'h0200,
    parameter int              RAMP_DIV = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [VOL_W-1:0]         volume,
    input  logic                     mute,
    input  logic [NUM_CH*DIV_W-1:0]  note_div,
    output logic [NUM_CH*AUD_W-1:0]  audio_out,
    output logic [NUM_CH-1:0]        ch_active
);

    localparam logic [63:0]      PEAK    = 64'(AMP_HI) << (MAX_VOL - 1);
    localparam int               PRE_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [VOL_W-1:0] MAX_LVL = VOL_W'(MAX_VOL);

    generate
        if (MAX_VOL < 1 || MAX_VOL >= (1 << VOL_W)) begin : g_bad_max_vol
            $error("tone_gen_multi: MAX_VOL must be 1..2**VOL_W-1");
        end
        if (RAMP_DIV < 1) begin : g_bad_ramp_div
            $error("tone_gen_multi: RAMP_DIV must be at least 1");
        end
        if ((PEAK >> AUD_W) != 64'd0) begin : g_bad_amp
            $error("tone_gen_multi: AMP_HI at MAX_VOL does not fit in AUD_W bits");
        end
    endgenerate

    function automatic logic [VOL_W-1:0] sat_volume(input logic [VOL_W-1:0] v);
        return (v > MAX_LVL) ? MAX_LVL : v;
    endfunction

    function automatic logic [VOL_W-1:0] step_level(input logic [VOL_W-1:0] cur,
                                                    input logic [VOL_W-1:0] tgt);
        if (cur < tgt)
            return cur + 1'b1;
        else if (cur > tgt)
            return cur - 1'b1;
        else
            return cur;
    endfunction

    // Each level above 1 doubles the amplitude of the level-1 waveform.
    function automatic logic [AUD_W-1:0] level_to_sample(input logic [VOL_W-1:0] lvl,
                                                         input logic             ph);
        logic [AUD_W-1:0] amp;
        amp = ph ? AMP_LO : AMP_HI;
        if (lvl == '0)
            return '0;
        else
            return amp << (lvl - 1'b1);
    endfunction

    logic [VOL_W-1:0] vol_sat;
    logic [PRE_W-1:0] pre_p0;
    logic             step_tick;

    assign vol_sat   = sat_volume(volume);
    assign step_tick = (pre_p0 == PRE_LAST);

    // Stage p0: shared ramp prescaler
    always_ff @(posedge clk) begin
        if (!rst)
            pre_p0 <= '0;
        else if (step_tick)
            pre_p0 <= '0;
        else
            pre_p0 <= pre_p0 + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_in;
        logic [DIV_W-1:0] div_q_p0;
        logic [DIV_W-1:0] cnt_p0;
        logic             phase_p0;
        logic [VOL_W-1:0] level_p0;
        logic [VOL_W-1:0] target;
        logic [AUD_W-1:0] sample_p1;
        logic             act_p1;

        assign div_in = note_div[i*DIV_W +: DIV_W];
        // A divider of 0 or 1 is the sequencer's way of saying "no note".
        assign target = (mute || (div_q_p0 <= DIV_W'(1))) ? '0 : vol_sat;

        // Stage p0: divider, phase and ramped level
        always_ff @(posedge clk) begin
            if (!rst) begin
                div_q_p0 <= '0;
                cnt_p0   <= '0;
                phase_p0 <= 1'b0;
                level_p0 <= '0;
            end else begin
                if (div_in != div_q_p0) begin
                    div_q_p0 <= div_in;
                    cnt_p0   <= '0;
                end else if (cnt_p0 >= div_q_p0) begin
                    cnt_p0   <= '0;
                    phase_p0 <= ~phase_p0;
                end else begin
                    cnt_p0 <= cnt_p0 + 1'b1;
                end
                if (step_tick)
                    level_p0 <= step_level(level_p0, target);
            end
        end

        // Stage p1: registered PCM sample and activity flag
        always_ff @(posedge clk) begin
            if (!rst) begin
                sample_p1 <= '0;
                act_p1    <= 1'b0;
            end else begin
                sample_p1 <= level_to_sample(level_p0, phase_p0);
                act_p1    <= (level_p0 != '0);
            end
        end

        assign audio_out[i*AUD_W +: AUD_W] = sample_p1;
        assign ch_active[i]                = act_p1;
    end

endmodule

// File: tb/tb_tone_gen_multi.sv
// Bench for tone_gen_multi: directed scenarios plus randomized traffic against a cycle model.
module tb_tone_gen_multi;
    localparam int NUM_CH   = 2;
    localparam int DIV_W    = 22;
    localparam int AUD_W    = 16;
    localparam int VOL_W    = 3;
    localparam int MAX_VOL  = 5;
    localparam int RAMP_DIV = 4;
    localparam int AMP_H    = 32'h0E00;
    localparam int AMP_L    = 32'h0200;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [VOL_W-1:0]        volume = '0;
    logic                    mute = 1'b0;
    logic [NUM_CH*DIV_W-1:0] note_div = '0;
    logic [NUM_CH*AUD_W-1:0] audio_out;
    logic [NUM_CH-1:0]       ch_active;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: plain integers per channel.
    int          m_div [NUM_CH];
    int          m_cnt [NUM_CH];
    int          m_ph  [NUM_CH];
    int          m_lvl [NUM_CH];
    int          m_pre;
    logic [31:0] m_audio;
    logic [1:0]  m_act;

    tone_gen_multi #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .AUD_W(AUD_W), .VOL_W(VOL_W), .MAX_VOL(MAX_VOL),
        .AMP_HI(16'h0E00), .AMP_LO(16'h0200), .RAMP_DIV(RAMP_DIV)
    ) dut (
        .clk(clk), .rst(rst), .volume(volume), .mute(mute), .note_div(note_div),
        .audio_out(audio_out), .ch_active(ch_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        int  tgt;
        int  nd;
        int  amp;
        bit  tick;
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = 0; m_cnt[i] = 0; m_ph[i] = 0; m_lvl[i] = 0;
            end
            m_pre   = 0;
            m_audio = '0;
            m_act   = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                amp = (m_lvl[i] == 0) ? 0 : (m_ph[i] != 0 ? AMP_L : AMP_H) * (2 ** (m_lvl[i] - 1));
                m_audio[i*AUD_W +: AUD_W] = amp[15:0];
                m_act[i] = (m_lvl[i] != 0);
            end
            tick  = (m_pre == RAMP_DIV - 1);
            m_pre = tick ? 0 : m_pre + 1;
            for (int i = 0; i < NUM_CH; i++) begin
                nd  = int'(note_div[i*DIV_W +: DIV_W]);
                tgt = (mute || m_div[i] <= 1) ? 0
                    : ((int'(volume) > MAX_VOL) ? MAX_VOL : int'(volume));
                if (tick) begin
                    if (tgt > m_lvl[i])      m_lvl[i] = m_lvl[i] + 1;
                    else if (tgt < m_lvl[i]) m_lvl[i] = m_lvl[i] - 1;
                end
                if (nd != m_div[i]) begin
                    m_div[i] = nd;
                    m_cnt[i] = 0;
                end else if (m_cnt[i] >= m_div[i]) begin
                    m_cnt[i] = 0;
                    m_ph[i]  = 1 - m_ph[i];
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        compared++;
        assert (audio_out === m_audio) else begin
            mismatched++;
            $error("FAIL %s audio_out: observed %h expected %h", tag, audio_out, m_audio);
        end
        compared++;
        assert (ch_active === m_act) else begin
            mismatched++;
            $error("FAIL %s ch_active: observed %b expected %b", tag, ch_active, m_act);
        end
    endtask

    task automatic cyc(input string tag);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) cyc(tag);
    endtask

    initial begin
        logic [15:0] prev;
        logic [15:0] v0;
        logic [15:0] v1;
        logic [15:0] ch0;
        bit          found;

        // T1: reset held with random inputs
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            volume   = 3'($urandom);
            mute     = 1'($urandom);
            note_div = {12'($urandom), 32'($urandom)};
            cyc("T1_reset");
            check_val("T1_audio_zero", 32'(audio_out), 32'h0);
            check_val("T1_active_zero", 32'(ch_active), 32'h0);
        end
        rst  = 1'b1;
        mute = 1'b1;
        cyc("T1_release");
        check_val("T1_release_audio", 32'(audio_out), 32'h0);
        check_val("T1_release_active", 32'(ch_active), 32'h0);

        // T2: ramp to full volume, ch0 div 3
        mute     = 1'b0;
        volume   = 3'd5;
        note_div = {22'd0, 22'd3};
        run(24, "T2_ramp");
        check_val("T2_active", 32'(ch_active), 32'h1);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            prev = audio_out[15:0];
            cyc("T2_seek");
            if (prev == 16'hE000 && audio_out[15:0] == 16'h2000) found = 1'b1;
        end
        check_val("T2_edge_found", 32'(found), 32'h1);
        run(3, "T2_tone");
        check_val("T2_lo_hold", 32'(audio_out[15:0]), 32'h2000);
        cyc("T2_tone");
        check_val("T2_hi_start", 32'(audio_out[15:0]), 32'hE000);
        run(3, "T2_tone");
        check_val("T2_hi_hold", 32'(audio_out[15:0]), 32'hE000);
        cyc("T2_tone");
        check_val("T2_lo_again", 32'(audio_out[15:0]), 32'h2000);
        check_val("T2_ch1_silent", 32'(audio_out[31:16]), 32'h0);

        // T3: clamp, then volume drop
        volume = 3'd7;
        run(8, "T3_clamp");
        ch0 = audio_out[15:0];
        check_val("T3_clamped_amp", 32'(ch0 == 16'hE000 || ch0 == 16'h2000), 32'h1);
        volume = 3'd2;
        run(20, "T3_drop");
        ch0 = audio_out[15:0];
        check_val("T3_level2_amp", 32'(ch0 == 16'h1C00 || ch0 == 16'h0400), 32'h1);

        // T4: mute both channels from full level
        volume   = 3'd5;
        note_div = {22'd5, 22'd3};
        run(28, "T4_up");
        check_val("T4_both_active", 32'(ch_active), 32'h3);
        mute = 1'b1;
        run(24, "T4_decay");
        check_val("T4_audio_zero", 32'(audio_out), 32'h0);
        check_val("T4_active_zero", 32'(ch_active), 32'h0);

        // T5: divider shrink mid-count preserves phase
        mute     = 1'b0;
        note_div = {22'd5, 22'd100};
        run(30, "T5_up");
        note_div[21:0] = 22'd3;
        cyc("T5_change");
        v0 = audio_out[15:0];
        check_val("T5_v0_valid", 32'(v0 == 16'hE000 || v0 == 16'h2000), 32'h1);
        v1 = (v0 == 16'hE000) ? 16'h2000 : 16'hE000;
        for (int k = 1; k <= 4; k++) begin
            cyc("T5_hold");
            check_val("T5_phase_held", 32'(audio_out[15:0]), 32'(v0));
        end
        cyc("T5_toggle");
        check_val("T5_first_toggle", 32'(audio_out[15:0]), 32'(v1));
        note_div[21:0] = 22'd1;
        run(25, "T5_silence");
        check_val("T5_ch0_off", 32'(ch_active), 32'h2);
        check_val("T5_ch0_audio", 32'(audio_out[15:0]), 32'h0);

        // T6: reset mid-ramp with a divider change on the same edge
        note_div = {22'd5, 22'd3};
        run(7, "T6_ramp");
        rst      = 1'b0;
        note_div = {22'd9, 22'd7};
        cyc("T6_reset");
        check_val("T6_audio_zero", 32'(audio_out), 32'h0);
        check_val("T6_active_zero", 32'(ch_active), 32'h0);
        rst = 1'b1;
        run(3, "T6_restart");
        check_val("T6_still_zero", 32'(ch_active), 32'h0);
        run(8, "T6_restart");

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 9) == 0)  volume = 3'($urandom);
            if ($urandom_range(0, 29) == 0) mute = ~mute;
            if ($urandom_range(0, 19) == 0) note_div[21:0]  = 22'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) note_div[43:22] = 22'($urandom_range(0, 12));
            rst = ($urandom_range(0, 199) != 0);
            cyc("RND");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
